ultrasonido_echo_responder: RTL and testbench
=============================================

// Module: ultrasonido_echo_responder
// PURPOSE
//  Emulates an HC-SR04-style ultrasonic sensor: it is the responder at the far end of the trigger/echo interface.
//  It watches the controller's trigger, checks the pulse width, waits out the burst time, then drives echo high.
//  The echo high time is proportional to the programmed distance_cm.
//  Used on-board for loopback tests of the distance controller without a physical sensor, and as the sim sensor model.
// PARAMETERS
//  TRIG_MIN_CYC  1000     min trigger high width in clk cycles (10 us @ 100 MHz)
//  BURST_CYC     20000    delay from trigger fall to echo rise (8x40 kHz burst, 200 us)
//  CYC_PER_CM    5800     echo high cycles per cm (58 us/cm round trip)
//  MAX_CM        400      largest in-range distance; above it -> no-target timeout
//  TIMEOUT_CYC   3800000  echo width for out-of-range target (38 ms)
//  HOLDOFF_CYC   100000   dead time after echo fall before a new trigger is accepted
// PORTS
//  clk          in   1   system clock, 100 MHz
//  reset        in   1   asynchronous, active-low reset
//  trigger      in   1   trigger from controller, asynchronous; synchronized internally
//  distance_cm  in   16  simulated target distance, sampled on accepted trigger fall
//  echo         out  1   echo pulse to controller, registered
//  busy         out  1   high in any state other than IDLE
//  trig_short   out  1   1-cycle pulse: trigger fell before TRIG_MIN_CYC was reached
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE; echo, busy and trig_short = 0; all counters = 0; sync flops = 0.
//  - If reset asserts during ECHO, echo drops immediately with no glitch back to high.
//  - trigger passes through a 2-flop synchronizer (trg_s). Edges are detected on trg_s against its 1-cycle delayed copy.
//  - FSM states:
//    IDLE: on rising trg_s -> TRIG_HI with wcnt=1.
//    TRIG_HI: wcnt increments each cycle and saturates at TRIG_MIN_CYC. On falling trg_s:
//      wcnt>=TRIG_MIN_CYC -> latch distance_cm, compute len, go to BURST;
//      otherwise -> pulse trig_short for 1 cycle and return to IDLE.
//    BURST: count BURST_CYC cycles, then -> ECHO with echo=1.
//    ECHO: echo stays high for exactly len cycles, then echo=0 and -> HOLDOFF.
//    HOLDOFF: count HOLDOFF_CYC cycles, then -> IDLE.
//  - Timing: the trg_s fall is seen in cycle N. BURST occupies cycles N+1 .. N+BURST_CYC.
//    echo is 1 from cycle N+1+BURST_CYC for len cycles.
//  - len, as 32-bit unsigned:
//    latched d==0      -> len=CYC_PER_CM (minimum 1 cm);
//    d>MAX_CM          -> len=TIMEOUT_CYC;
//    otherwise         -> len=d*CYC_PER_CM (16x16 multiply, 32-bit result, no overflow for d<=MAX_CM).
//  - Changing distance_cm after the latch has no effect on the pulse in progress.
//  - Trigger edges seen in BURST, ECHO or HOLDOFF are ignored; no queuing and no restart.
//  - Trigger still high on entry to IDLE: a rising edge is needed to start a new measurement.
//  - Counters are 32-bit. Every compare uses >= so a parameter of 0 or 1 gives a 1-cycle state.
// CONFIGURATION
//  - ECHO_JITTER_EN defined: an 8-bit Fibonacci LFSR runs in every state.
//    Polynomial x^8+x^6+x^5+x^4+1, reset seed 8'hA5.
//    At the latch, len += {28'b0, lfsr[3:0]}, i.e. 0..15 extra cycles of bounded, repeatable jitter.
//    The timeout length also gets the jitter.
//  - ECHO_JITTER_EN undefined: no LFSR logic; len is exact as above.
// TESTING
//  Bench parameters: TRIG_MIN_CYC=10, BURST_CYC=20, CYC_PER_CM=5, MAX_CM=400, TIMEOUT_CYC=3000, HOLDOFF_CYC=50.
//  1. Nominal: distance_cm=100, trigger high 12 cycles -> echo rises 21 cycles after trg_s fall, high exactly 500 cycles; busy high throughout.
//  2. Short trigger: trigger high 5 cycles -> trig_short 1-cycle pulse, echo stays 0, state back to IDLE.
//  3. Range limits: d=0 -> echo 5 cycles; d=400 -> 2000 cycles; d=401 and d=16'hFFFF -> 3000 cycles.
//  4. Retrigger: pulse trigger during ECHO and during HOLDOFF -> ignored, echo width unchanged; trigger after HOLDOFF -> new measurement.
//  5. Async reset: reset=0 mid-ECHO -> echo=0 and busy=0 in the same cycle; after release, a 12-cycle trigger gives a normal echo.
//  6. ECHO_JITTER_EN defined, d=100 -> each echo width is in 500..515; the sequence after reset matches the LFSR model from seed 8'hA5.

Source files
------------

// File: rtl/ultrasonido_echo_responder.sv
// HC-SR04 style responder. It checks the trigger width, waits out the burst time, then drives an echo whose width is proportional to distance_cm.
// Optional macro ECHO_JITTER_EN adds 0..15 cycles of repeatable LFSR jitter to each echo.
module ultrasonido_echo_responder #(
    parameter int unsigned TRIG_MIN_CYC = 1000,
    parameter int unsigned BURST_CYC    = 20000,
    parameter int unsigned CYC_PER_CM   = 5800,
    parameter int unsigned MAX_CM       = 400,
    parameter int unsigned TIMEOUT_CYC  = 3800000,
    parameter int unsigned HOLDOFF_CYC  = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [15:0] distance_cm,
    output logic        echo,
    output logic        busy,
    output logic        trig_short
);

    localparam logic [31:0] P_TRIG  = 32'(TRIG_MIN_CYC);
    localparam logic [31:0] P_BURST = 32'(BURST_CYC);
    localparam logic [31:0] P_CPC   = 32'(CYC_PER_CM);
    localparam logic [31:0] P_MAX   = 32'(MAX_CM);
    localparam logic [31:0] P_TOUT  = 32'(TIMEOUT_CYC);
    localparam logic [31:0] P_HOLD  = 32'(HOLDOFF_CYC);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG_HI = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        trg_m_q, trg_s_q, trg_p_q;
    logic        trg_rise, trg_fall;
    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] len_q, len_d, len_base, len_new, prod;
    logic        echo_q, echo_d;
    logic        short_q, short_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trg_m_q <= 1'b0;
            trg_s_q <= 1'b0;
            trg_p_q <= 1'b0;
        end else begin
            trg_m_q <= trigger;
            trg_s_q <= trg_m_q;
            trg_p_q <= trg_s_q;
        end
    end

    assign trg_rise = trg_s_q & ~trg_p_q;
    assign trg_fall = ~trg_s_q & trg_p_q;

    assign prod = {16'b0, distance_cm} * P_CPC;

    always_comb begin
        if (distance_cm == 16'd0) begin
            len_base = P_CPC;
        end else if ({16'b0, distance_cm} > P_MAX) begin
            len_base = P_TOUT;
        end else begin
            len_base = prod;
        end
    end

`ifdef ECHO_JITTER_EN
    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; free-running so jitter depends on trigger timing.
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign len_new = len_base + {28'b0, lfsr_q[3:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign len_new = len_base;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        echo_d  = echo_q;
        short_d = 1'b0;
        cnt_inc = cnt_q + 32'd1;
        case (state_q)
            IDLE: begin
                if (trg_rise) begin
                    state_d = TRIG_HI;
                    cnt_d   = 32'd1;
                end
            end
            TRIG_HI: begin
                if (trg_fall) begin
                    cnt_d = 32'd0;
                    if (cnt_q >= P_TRIG) begin
                        len_d   = len_new;
                        state_d = BURST;
                    end else begin
                        short_d = 1'b1;
                        state_d = IDLE;
                    end
                end else if (cnt_q < P_TRIG) begin
                    cnt_d = cnt_inc;
                end
            end
            BURST: begin
                if (cnt_inc >= P_BURST) begin
                    cnt_d   = 32'd0;
                    echo_d  = 1'b1;
                    state_d = ECHO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ECHO: begin
                if (cnt_inc >= len_q) begin
                    cnt_d   = 32'd0;
                    echo_d  = 1'b0;
                    state_d = HOLDOFF;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HOLDOFF: begin
                if (cnt_inc >= P_HOLD) begin
                    cnt_d   = 32'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 32'd0;
                echo_d  = 1'b0;
            end
        endcase
    end

    // echo is a flop with async clear so reset drops it at once without a glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            len_q   <= 32'd0;
            echo_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            echo_q  <= echo_d;
            short_q <= short_d;
        end
    end

    assign echo       = echo_q;
    assign trig_short = short_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ultrasonido_echo_responder.sv
// Randomized bench for ultrasonido_echo_responder: expected echo timing and width come from the
// distance rules (plus the LFSR jitter model when ECHO_JITTER_EN is defined).
module tb_ultrasonido_echo_responder;

    localparam int TMIN  = 10;
    localparam int BURST = 20;
    localparam int CPC   = 5;
    localparam int MAXCM = 400;
    localparam int TOUT  = 3000;
    localparam int HOLD  = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] distance_cm = 16'd0;
    logic        echo, busy, trig_short;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    ultrasonido_echo_responder #(
        .TRIG_MIN_CYC(TMIN), .BURST_CYC(BURST), .CYC_PER_CM(CPC),
        .MAX_CM(MAXCM), .TIMEOUT_CYC(TOUT), .HOLDOFF_CYC(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .distance_cm(distance_cm),
        .echo(echo), .busy(busy), .trig_short(trig_short)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Jitter reference: the LFSR sequence from seed 8'hA5, restarted by every reset.
    logic [7:0] m_lfsr = 8'hA5;
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // Pulse monitor on the opposite clock edge.
    logic echo_prev = 1'b0, ts_prev = 1'b0;
    int rise_cyc = 0, last_rise = 0, last_width = 0, echo_cnt = 0;
    int short_len = 0, last_short_len = 0, short_cnt = 0;
    always @(negedge clk) begin
        if (echo === 1'b1 && !echo_prev) rise_cyc = cyc;
        if (echo !== 1'b1 && echo_prev) begin
            last_rise  = rise_cyc;
            last_width = cyc - rise_cyc;
            echo_cnt++;
        end
        if (trig_short === 1'b1) begin
            short_len++;
        end else if (ts_prev) begin
            last_short_len = short_len;
            short_len = 0;
            short_cnt++;
        end
        echo_prev = (echo === 1'b1);
        ts_prev   = (trig_short === 1'b1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_len(input int d);
        if (d == 0)     return CPC;
        if (d > MAXCM)  return TOUT;
        return d * CPC;
    endfunction

    task automatic measure(input int h, input int d, input bit retrig, input string tag);
        int n0, fall_c, len, jit, i, f_cyc;
        n0 = echo_cnt;
        @(negedge clk);
        distance_cm = 16'(d);
        trigger = 1'b1;
        repeat (h) @(negedge clk);
        trigger = 1'b0;
        fall_c = cyc;
        repeat (2) @(negedge clk);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
`ifdef ECHO_JITTER_EN
        jit = int'(m_lfsr[3:0]);
`else
        jit = 0;
`endif
        @(negedge clk);
        distance_cm = 16'($urandom);
        len = exp_len(d) + jit;
        for (i = 0; i < BURST + 20 && echo !== 1'b1; i++) @(negedge clk);
        if (retrig) begin
            trigger = 1'b1;
            repeat (12) @(negedge clk);
            trigger = 1'b0;
        end
        for (i = 0; i < len + 40 && echo_cnt == n0; i++) @(negedge clk);
        chk({tag, "_echo_seen"}, 64'(echo_cnt != n0), 64'd1);
        if (retrig) begin
            repeat (2) @(negedge clk);
            trigger = 1'b1;
            repeat (12) @(negedge clk);
            trigger = 1'b0;
        end
        // two synchronizer flops, then BURST cycles, then echo
        chk({tag, "_rise"}, 64'(last_rise - fall_c), 64'(BURST + 3));
        chk({tag, "_width"}, 64'(last_width), 64'(len));
`ifdef ECHO_JITTER_EN
        chk({tag, "_jit_range"}, 64'(last_width >= exp_len(d) && last_width <= exp_len(d) + 15), 64'd1);
`endif
        f_cyc = last_rise + last_width;
        for (i = 0; i < HOLD + 40 && busy !== 1'b0; i++) @(negedge clk);
        chk({tag, "_holdoff"}, 64'(cyc - f_cyc), 64'(HOLD));
        if (retrig) begin
            repeat (30) @(negedge clk);
            chk({tag, "_no_restart"}, 64'(echo_cnt - n0), 64'd1);
            chk({tag, "_idle"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic short_trig(input int h, input string tag);
        int n0, s0;
        n0 = echo_cnt;
        s0 = short_cnt;
        @(negedge clk);
        distance_cm = 16'($urandom);
        trigger = 1'b1;
        repeat (h) @(negedge clk);
        trigger = 1'b0;
        repeat (8) @(negedge clk);
        chk({tag, "_pulse"}, 64'(short_cnt - s0), 64'd1);
        chk({tag, "_pulse_len"}, 64'(last_short_len), 64'd1);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        repeat (BURST + 10) @(negedge clk);
        chk({tag, "_no_echo"}, 64'(echo_cnt - n0), 64'd0);
    endtask

    initial begin
        int d, i;
        repeat (3) @(negedge clk);
        chk("rst_echo", 64'(echo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_short", 64'(trig_short), 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        measure(12, 100, 1'b0, "nominal");
        measure(12, 100, 1'b1, "retrig");
        measure(12, 100, 1'b0, "after_retrig");

        short_trig(5, "short5");
        short_trig(TMIN - 1, "short_edge");
        for (i = 0; i < 3; i++) short_trig($urandom_range(1, TMIN - 1), "short_rand");

        measure(TMIN, 1, 1'b0, "min_width");
        measure(12, 0, 1'b0, "d0");
        measure(12, 400, 1'b0, "d400");
        measure(12, 401, 1'b0, "d401");
        measure(12, 16'hFFFF, 1'b0, "dffff");

        for (i = 0; i < 6; i++) begin
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(401, 65535))
                                            : int'($urandom_range(0, MAXCM));
            measure($urandom_range(TMIN, TMIN + 10), d, 1'b0, "rand");
        end

        // Asynchronous reset in the middle of an echo.
        @(negedge clk);
        distance_cm = 16'd100;
        trigger = 1'b1;
        repeat (12) @(negedge clk);
        trigger = 1'b0;
        for (i = 0; i < BURST + 20 && echo !== 1'b1; i++) @(negedge clk);
        chk("arst_echo_before", 64'(echo), 64'd1);
        repeat (30) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_echo", 64'(echo), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("arst_hold_echo", 64'(echo), 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        measure(12, 100, 1'b0, "post_arst");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
